// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared defaults and types for the instruction-fetch stage.
//   DEF_ADDR_W / DEF_DATA_W : default address and instruction widths
//   fetch_state_t           : fetch FSM states
//   NOP_INSTR               : value presented on inst_data while nothing is buffered
package ifetch_pkg;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: instruction-memory and decode-side handshakes of the fetch stage.
//   imem_req_*  : fetch request (valid/ready, word-aligned address)
//   imem_rsp_*  : in-order response, always accepted
//   inst_*      : decode-side valid/ready with instruction word and its PC
//   master      : fetch-unit view; slave : memory/decode view
interface ifetch_if
   import ifetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();
   logic              imem_req_valid;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_req_ready;
   logic              imem_rsp_valid;
   logic [DATA_W-1:0] imem_rsp_data;
   logic              inst_valid;
   logic [DATA_W-1:0] inst_data;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_ready;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
   );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO with registered storage and head read-out.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : drop all entries (same effect as reset on the pointers)
//   push/din     : write din at the tail
//   pop          : advance the head (ignored when empty)
//   dout         : head entry; count/full/empty : occupancy
module ifetch_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 2,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt_q;
   logic          do_pop;

   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q == CW'(DEPTH));
   assign count  = cnt_q;
   assign dout   = mem[rd_ptr];
   assign do_pop = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Upstream credit accounting must never let a push land on a full queue.
   always_ff @(posedge clock) begin
      if (!reset) assert (!(push && full)) else $error("ifetch_fifo: push while full");
   end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage between the PC register and decode.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   pc_in        : current PC; pc_advance : request accepted, PC register steps
//   redirect     : branch/jump taken; flush buffered and in-flight fetches
//   bus          : imem request/response and decode handshakes (ifetch_if.master)
// Every issued request holds one credit until its instruction leaves the output
// queue, so the output queue can never overflow.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              pc_advance,
   input  logic              redirect,
   ifetch_if.master          bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t      state_q, state_d;
   logic [CW-1:0]     drop_q, drop_d;
   logic [CW-1:0]     fifo_cnt, outstanding;
   logic [CW:0]       used;
   logic              has_credit, req_fire, rsp_keep, flush, out_pop;
   logic              tag_full, tag_empty, out_full, out_empty;
   logic [ADDR_W-1:0] tag;
   logic [ADDR_W+DATA_W-1:0] head;
   logic              unused_bits;

   assign bus.imem_req_addr = {pc_in[ADDR_W-1:2], 2'b00};
   assign used       = {1'b0, fifo_cnt} + {1'b0, outstanding};
   assign has_credit = used < (CW+1)'(DEPTH);
   assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
   assign pc_advance = req_fire;

   // drop_q is only ever nonzero in DRAIN, so FETCH keeps every response
   // unless a redirect lands in the same cycle.
   always_comb begin
      state_d            = state_q;
      drop_d             = drop_q;
      bus.imem_req_valid = 1'b0;
      rsp_keep           = 1'b0;
      flush              = 1'b0;
      case (state_q)
         FETCH: begin
            bus.imem_req_valid = has_credit && !redirect && !reset;
            rsp_keep           = bus.imem_rsp_valid && !redirect;
            if (redirect) begin
               flush  = 1'b1;
               // A response arriving now is already discarded; only later ones count.
               drop_d = outstanding - CW'(bus.imem_rsp_valid);
               if (drop_d != '0) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.imem_rsp_valid) begin
               drop_d = drop_q - CW'(1);
               if (drop_q == CW'(1)) state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= FETCH;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   // PC tags of in-flight requests; its occupancy is the outstanding count.
   ifetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tagq (
      .clock (clock),
      .reset (reset),
      .clear (1'b0),
      .push  (req_fire),
      .pop   (bus.imem_rsp_valid),
      .din   (bus.imem_req_addr),
      .dout  (tag),
      .count (outstanding),
      .full  (tag_full),
      .empty (tag_empty)
   );

   // Flush beats a same-cycle decode pop; decode squashes that instruction.
   assign out_pop = bus.inst_valid && bus.inst_ready && !flush;

   ifetch_fifo #(.W(ADDR_W+DATA_W), .DEPTH(DEPTH)) u_outq (
      .clock (clock),
      .reset (reset),
      .clear (flush),
      .push  (rsp_keep),
      .pop   (out_pop),
      .din   ({tag, bus.imem_rsp_data}),
      .dout  (head),
      .count (fifo_cnt),
      .full  (out_full),
      .empty (out_empty)
   );

   assign bus.inst_valid = !out_empty;
   assign bus.inst_pc    = out_empty ? '0 : head[ADDR_W+DATA_W-1:DATA_W];
   assign bus.inst_data  = out_empty ? DATA_W'(NOP_INSTR) : head[DATA_W-1:0];

   assign unused_bits = &{1'b0, pc_in[1:0], tag_full, out_full};

   // A response with nothing outstanding means the memory was not reset with us.
   always_ff @(posedge clock) begin
      if (!reset) assert (!(bus.imem_rsp_valid && tag_empty)) else $error("ifetch_unit: response with no request outstanding");
   end
endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
   import ifetch_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int DEPTH = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] pc_in;
   logic          pc_advance;
   logic          redirect;

   ifetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ifetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .pc_in      (pc_in),
      .pc_advance (pc_advance),
      .redirect   (redirect),
      .bus        (bus.master)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } req_t;

   int            total, bad, cyc_n, lat, fires;
   logic          rst_v, redir_v, mem_ready, iready;
   logic [AW-1:0] pc, redir_tgt;
   req_t          mq[$];
   logic [AW-1:0] cap_pc[$];
   logic [DW-1:0] cap_data[$];

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return (a << 4) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs at negedge, let logic settle, then model
   // the memory, the PC register and the decode consumer.
   task automatic cyc();
      req_t r;
      @(negedge clock);
      reset              = rst_v;
      redirect           = redir_v;
      bus.imem_req_ready = mem_ready;
      bus.inst_ready     = iready;
      pc_in              = pc;
      if (rst_v) mq.delete();
      if (mq.size() > 0 && mq[0].due <= cyc_n) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = memf(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end
      #1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         r.addr = bus.imem_req_addr;
         r.due  = cyc_n + lat;
         mq.push_back(r);
         fires++;
      end
      if (bus.inst_valid && bus.inst_ready && !redir_v && !rst_v) begin
         cap_pc.push_back(bus.inst_pc);
         cap_data.push_back(bus.inst_data);
      end
      if (redir_v) pc = redir_tgt;
      else if (pc_advance) pc = pc + 32'd4;
      cyc_n++;
   endtask

   task automatic do_reset(input logic [AW-1:0] start_pc);
      rst_v   = 1'b1;
      redir_v = 1'b0;
      repeat (3) cyc();
      rst_v = 1'b0;
      pc    = start_pc;
      fires = 0;
      cap_pc.delete();
      cap_data.delete();
   endtask

   initial begin
      total = 0; bad = 0; cyc_n = 0; fires = 0; lat = 1;
      rst_v = 1'b1; redir_v = 1'b0; mem_ready = 1'b1; iready = 1'b0;
      pc = '0; redir_tgt = '0;
      reset = 1'b1; redirect = 1'b0; pc_in = '0;
      bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = '0; bus.inst_ready = 1'b0;

      // Reset state and first fetch
      do_reset(32'h0);
      chk("rst_inst_valid", bus.inst_valid, 0);
      chk("rst_inst_data", bus.inst_data, 0);
      chk("rst_inst_pc", bus.inst_pc, 0);
      chk("rst_req_valid", bus.imem_req_valid, 0);
      cyc();
      chk("t1_req_valid", bus.imem_req_valid, 1);
      chk("t1_req_addr", bus.imem_req_addr, 32'h0);
      chk("t1_adv", pc_advance, 1);
      cyc();
      chk("t1_inst_early", bus.inst_valid, 0);
      cyc();
      chk("t1_inst_valid", bus.inst_valid, 1);
      chk("t1_inst_pc", bus.inst_pc, 32'h0);
      chk("t1_inst_data", bus.inst_data, memf(32'h0));
      chk("t1_no_credit", bus.imem_req_valid, 0);
      repeat (2) cyc();
      chk("t1_fires", fires, 2);

      // Streaming
      do_reset(32'h100);
      iready = 1'b1;
      repeat (20) cyc();
      chk("t2_count", cap_pc.size() >= 6, 1);
      for (int i = 0; i < 6; i++) begin
         if (i < cap_pc.size()) begin
            chk($sformatf("t2_pc%0d", i), cap_pc[i], 32'h100 + 32'(4*i));
            chk($sformatf("t2_data%0d", i), cap_data[i], memf(32'h100 + 32'(4*i)));
         end
      end

      // Decode backpressure
      do_reset(32'h100);
      iready = 1'b0;
      repeat (10) cyc();
      chk("t3_fires", fires, 2);
      chk("t3_req_valid", bus.imem_req_valid, 0);
      chk("t3_inst_pc", bus.inst_pc, 32'h100);
      iready = 1'b1;
      repeat (3) cyc();
      chk("t3_count", cap_pc.size() >= 2, 1);
      if (cap_pc.size() >= 2) begin
         chk("t3_pc0", cap_pc[0], 32'h100);
         chk("t3_pc1", cap_pc[1], 32'h104);
      end

      // Redirect with two fetches outstanding
      do_reset(32'h100);
      iready = 1'b1; lat = 3;
      repeat (2) cyc();
      redir_v = 1'b1; redir_tgt = 32'h400;
      cyc();
      chk("t4_redir_req", bus.imem_req_valid, 0);
      chk("t4_redir_adv", pc_advance, 0);
      redir_v = 1'b0;
      cyc();
      cyc();
      chk("t4_drain_req", bus.imem_req_valid, 0);
      chk("t4_drain_inst", bus.inst_valid, 0);
      cyc();
      chk("t4_resume_req", bus.imem_req_valid, 1);
      chk("t4_resume_addr", bus.imem_req_addr, 32'h400);
      repeat (6) cyc();
      chk("t4_count", cap_pc.size() >= 1, 1);
      if (cap_pc.size() >= 1) begin
         chk("t4_pc0", cap_pc[0], 32'h400);
         chk("t4_data0", cap_data[0], memf(32'h400));
      end

      // Redirect colliding with the only outstanding response
      do_reset(32'h200);
      iready = 1'b1; lat = 2; mem_ready = 1'b1;
      cyc();
      mem_ready = 1'b0;
      cyc();
      chk("t5_hold_valid", bus.imem_req_valid, 1);
      chk("t5_hold_addr", bus.imem_req_addr, 32'h204);
      redir_v = 1'b1; redir_tgt = 32'h302;
      cyc();
      chk("t5_redir_req", bus.imem_req_valid, 0);
      chk("t5_redir_adv", pc_advance, 0);
      redir_v = 1'b0; mem_ready = 1'b1;
      cyc();
      chk("t5_resume_req", bus.imem_req_valid, 1);
      chk("t5_resume_addr", bus.imem_req_addr, 32'h300);
      chk("t5_dropped", bus.inst_valid, 0);
      repeat (5) cyc();
      chk("t5_count", cap_pc.size() >= 1, 1);
      if (cap_pc.size() >= 1) begin
         chk("t5_pc0", cap_pc[0], 32'h300);
         chk("t5_data0", cap_data[0], memf(32'h300));
      end

      // Reset mid-stream with the output queue full
      do_reset(32'h100);
      iready = 1'b0; lat = 1;
      repeat (5) cyc();
      chk("t6_buffered", bus.inst_valid, 1);
      rst_v = 1'b1; pc = 32'h500;
      cyc();
      chk("t6_rst_req", bus.imem_req_valid, 0);
      rst_v = 1'b0; fires = 0;
      cyc();
      chk("t6_inst_valid", bus.inst_valid, 0);
      chk("t6_inst_pc", bus.inst_pc, 0);
      chk("t6_req_valid", bus.imem_req_valid, 1);
      chk("t6_req_addr", bus.imem_req_addr, 32'h500);
      repeat (4) cyc();
      chk("t6_fires", fires, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch stage directly downstream of the program-counter register.
- Takes the current PC, issues word-aligned requests to instruction memory over a valid/ready handshake, and pairs each in-order response with its PC.
- Buffers results in a small FIFO toward decode.
- Tells the PC register when to advance, and discards in-flight fetches on a branch/jump redirect.

Parameters:
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction word width
DEPTH, 2, output FIFO entries; also the maximum outstanding-plus-buffered fetches (power of 2, >=2)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
pc_in  in  ADDR_W  current PC from the PC register
pc_advance  out  1  combinational; high in the cycle a fetch request is accepted; PC register loads next PC
redirect  in  1  branch/jump taken this cycle; flush the fetch stream
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  ADDR_W  {pc_in[ADDR_W-1:2],2'b00}
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  response valid; in order; always accepted
imem_rsp_data  in  DATA_W  instruction word
inst_valid  out  1  decode-side valid
inst_data  out  DATA_W  instruction at FIFO head
inst_pc  out  ADDR_W  PC of the instruction at FIFO head
inst_ready  in  1  decode accepts head

Behaviour:
- Reset: synchronous, active-high.
  - FIFO empty; outstanding=0; drop=0; state=FETCH.
  - inst_valid=0, inst_data=0, inst_pc=0, imem_req_valid=0.
  - First request may assert in the first cycle with reset low.
- Credit rule: credits = DEPTH - (fifo_count + outstanding).
  - In state FETCH: imem_req_valid = (credits>0) && !redirect.
  - Credit is not reused combinationally: a same-cycle FIFO pop does not enable a request that cycle.
- Request accepted (valid && ready):
  - pc_advance=1 the same cycle.
  - Push imem_req_addr into a PC tag queue (DEPTH entries); outstanding+1.
- Response arrives:
  - Pop the PC tag; outstanding-1.
  - If drop>0: discard and decrement drop.
  - Else push {tag, imem_rsp_data} into the FIFO.
  - Credits guarantee the FIFO is never full at push; an overflow assertion must fire otherwise.
- Output: inst_* reflect the FIFO head (registered storage); pop when inst_valid && inst_ready. Minimum latency: request accepted at cycle N, response at N+k, visible at inst_valid in N+k+1.
- FSM, state FETCH:
  - On redirect: FIFO cleared, no request that cycle, pc_advance=0.
  - drop <= outstanding, minus 1 if a response arrives the same cycle, counting only responses that arrive in later cycles (see redirect/response entry below).
  - Go to DRAIN if that value >0, else stay in FETCH.
- FSM, state DRAIN:
  - imem_req_valid=0; responses discarded.
  - When the last dropped response arrives (drop==1 && imem_rsp_valid), go to FETCH; requests resume the next cycle from pc_in, which the PC register has already loaded with the target.
  - Redirect in DRAIN: FIFO already empty, drop unchanged, stay in DRAIN.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - Redirect and response in the same cycle: the response is discarded and is not counted in the new drop.
  - Redirect and inst_ready in the same cycle: the flush wins; decode treats the popped instruction as squashed.
- imem_req_valid, once asserted, holds with a stable address until ready, unless redirect arrives. A redirect may withdraw the request, as permitted by the memory protocol.
- Reset mid-operation: all state cleared next edge. The memory must also be reset; any stale responses after reset are a protocol violation.
- Counters are $clog2(DEPTH)+1 bits; no wrap permitted. FIFO pointers wrap modulo DEPTH.

Decomposition:
- Package ifetch_pkg: ADDR_W/DATA_W defaults, fetch_state_t enum {FETCH, DRAIN}, NOP_INSTR constant 32'h0000_0000.
- Sub-module ifetch_fifo: parameterised synchronous FIFO with push/pop/clear, count, full/empty. Instantiated twice: PC tag queue (ADDR_W), output queue (ADDR_W+DATA_W).

Test Plan:
- Reset held 3 cycles, then released, pc_in=0x0, memory ready=1, 1-cycle latency -> first request addr 0x0 in first cycle after reset; inst_valid with inst_pc=0x0 and data=mem[0] two cycles after acceptance; pc_advance pulses once per accepted request.
- Streaming with inst_ready=1, latency 1, pc_in incrementing by 4 from 0x100 -> inst_pc sequence 0x100,0x104,0x108,... with no gaps after fill.
- inst_ready=0 for 10 cycles -> at most 2 requests accepted, imem_req_valid drops, no FIFO overflow; on release, instructions 0x100,0x104 are delivered in order.
- 2 requests outstanding (latency 3), redirect to 0x400 -> state DRAIN, both responses discarded, next request addr 0x400, first inst_pc=0x400.
- Redirect on the same cycle as a response with 1 outstanding -> response dropped, no DRAIN entry, fetch resumes the next cycle.
- Reset asserted mid-stream with 2 entries buffered -> inst_valid=0 after the edge, counters 0, fetch restarts from pc_in.
